// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer.
// Holds the FSM encoding, default widths and opcodes.
package alu_sequencer_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_BITS  = 4;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC_LO,
    EXEC_HI,
    DONE
  } state_t;

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational WIDTH-bit ALU with carry/borrow in and S/Z/C/V flags.
// SUB computes a - b - cin; C is then the borrow out.
module alu
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int BITS  = ALU_BITS
) (
  input  logic [BITS-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             s,
  output logic             z,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           sa;
  logic           sb;

  assign sa   = a[WIDTH-1];
  assign sb   = b[WIDTH-1];
  assign sum  = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b}
              - {{WIDTH{1'b0}}, cin};

  always_comb begin
    result = a;
    c      = 1'b0;
    v      = 1'b0;
    unique case (1'b1)
      op == BITS'(OP_ADD): begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (sa == sb)
               && (sum[WIDTH-1] != sa);
      end
      op == BITS'(OP_SUB): begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (sa != sb)
               && (diff[WIDTH-1] != sa);
      end
      op == BITS'(OP_AND): result = a & b;
      op == BITS'(OP_OR):  result = a | b;
      op == BITS'(OP_XOR): result = a ^ b;
      default: result = a;
    endcase
  end

  assign s = result[WIDTH-1];
  assign z = ~|result;

endmodule

// File: rtl/alu_sequencer.sv
// Runs WIDTH or 2*WIDTH operations through one ALU in one or two
// passes, chaining the low-pass carry into the high pass.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int BITS  = ALU_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITS-1:0]    in_op,
  input  logic               in_wide,
  input  logic               in_cin,
  input  logic [2*WIDTH-1:0] in_a,
  input  logic [2*WIDTH-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_s,
  output logic               out_z,
  output logic               out_c,
  output logic               out_v,
  output logic               busy
);

  state_t state;
  state_t state_next;

  logic [BITS-1:0]    op_q;
  logic               wide_q;
  logic               cin_q;
  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] b_q;

  logic               hi;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               alu_cin;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_s;
  logic               alu_z;
  logic               alu_c;
  logic               alu_v;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign hi      = (state == EXEC_HI);
  assign alu_a   = hi ? a_q[2*WIDTH-1:WIDTH]
                      : a_q[WIDTH-1:0];
  assign alu_b   = hi ? b_q[2*WIDTH-1:WIDTH]
                      : b_q[WIDTH-1:0];
  assign alu_cin = hi ? out_c : cin_q;

  alu #(
    .WIDTH (WIDTH),
    .BITS  (BITS)
  ) u_alu (
    .op     (op_q),
    .a      (alu_a),
    .b      (alu_b),
    .cin    (alu_cin),
    .result (alu_r),
    .s      (alu_s),
    .z      (alu_z),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = EXEC_LO;
      EXEC_LO: state_next = wide_q ? EXEC_HI : DONE;
      EXEC_HI: state_next = DONE;
      DONE: begin
        if (out_valid && out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // out_valid lags DONE entry by one edge, so DONE waits for it
  always_ff @(posedge clk) begin
    if (rst)
      out_valid <= 1'b0;
    else if (out_valid && out_ready)
      out_valid <= 1'b0;
    else if (state == DONE)
      out_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      wide_q     <= 1'b0;
      cin_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      out_result <= '0;
      out_s      <= 1'b0;
      out_z      <= 1'b0;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= in_op;
            wide_q <= in_wide;
            cin_q  <= in_cin;
            a_q    <= in_a;
            b_q    <= in_b;
          end
        end
        EXEC_LO: begin
          out_result <= {{WIDTH{1'b0}}, alu_r};
          out_s      <= alu_s;
          out_z      <= alu_z;
          out_c      <= alu_c;
          out_v      <= alu_v;
        end
        EXEC_HI: begin
          out_result[2*WIDTH-1:WIDTH] <= alu_r;
          out_s <= alu_s;
          out_z <= out_z & alu_z;
          out_c <= alu_c;
          out_v <= alu_v;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, ALU word width.
REQ-002 SHALL have parameter BITS, default 4, ALU opcode width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 SHALL have port in_op, input, BITS, ALU opcode.
REQ-008 SHALL have port in_wide, input, 1, 1 selects a 2*WIDTH operation, 0 selects a WIDTH operation.
REQ-009 SHALL have port in_cin, input, 1, carry-in for the first pass.
REQ-010 SHALL have ports in_a and in_b, input, 2*WIDTH, operands; the upper halves are ignored when in_wide=0.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high at a clk edge.
REQ-013 SHALL have port out_result, output, 2*WIDTH, result; the upper half is 0 for narrow operations.
REQ-014 SHALL have ports out_s, out_z, out_c and out_v, output, 1 each, registered sign, zero, carry and overflow flags.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC_LO, EXEC_HI and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; on accept, SHALL capture in_op, in_wide, in_cin, in_a and in_b, then go to EXEC_LO.
REQ-018 In EXEC_LO, SHALL drive the ALU with the captured low WIDTH bits and C_in = captured cin.
REQ-019 In EXEC_LO, SHALL register the ALU result into result[WIDTH-1:0] and latch its S, Z, C and V.
REQ-020 From EXEC_LO, SHALL go to EXEC_HI if wide, else to DONE.
REQ-021 In EXEC_HI, SHALL drive the ALU with the captured high halves and C_in = the C latched in EXEC_LO.
REQ-022 In EXEC_HI, SHALL register result[2W-1:W] and go to DONE.
REQ-023 Wide flags: S, C and V SHALL come from the high pass; Z SHALL be Z_lo AND Z_hi.
REQ-024 In DONE, out_valid SHALL be 1, and out_result and flags SHALL be held stable until out_ready.
REQ-025 A handshake in DONE SHALL return the FSM to IDLE; there SHALL be no same-cycle re-accept.
REQ-026 Latency, accept edge k: out_valid SHALL rise after edge k+2 for narrow and after edge k+3 for wide operations.
REQ-027 in_ready SHALL be 0 outside IDLE; in_valid during busy SHALL be ignored, not queued.
REQ-028 Flag outputs SHALL retain the last completed operation's values after the DONE to IDLE transition.
REQ-029 Input operands SHALL be sampled only at accept; later input changes SHALL NOT affect the operation in flight.

Reset
REQ-030 When rst is high at a clk edge, SHALL go to IDLE, clear out_valid, out_result and all flags to 0, and drop any operation in flight, regardless of state.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the default WIDTH and BITS, and opcode constants OP_ADD=0 and OP_SUB=1.
REQ-033 SHALL instantiate exactly one sub-module, the existing alu, shared by both passes.

Verification
REQ-034 Narrow add: OP_ADD, A=10, B=5, cin=0, wide=0 -> result 15; S=0, Z=0, C=0; out_valid after 2 edges.
REQ-035 Narrow subtract: OP_SUB, A=10, B=10, wide=0 -> result 0, Z=1, S=0.
REQ-036 Wide carry chain: OP_ADD, A=0x0000FFFF, B=0x00000001, wide=1 -> result 0x00010000, C=0, Z=0; out_valid after 3 edges.
REQ-037 Wide wrap: OP_ADD, A=0xFFFFFFFF, B=0x00000001 -> result 0, C=1, Z=1.
REQ-038 Backpressure: out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0, an extra in_valid pulse is ignored.
REQ-039 Reset mid-op: rst during EXEC_HI -> next cycle IDLE, out_valid=0, flags=0, in_ready=1.
